// File: rtl/phivers_inject_arbiter_pkg.sv
// Shared types and constants for the PHIVERS boundary-port packet injector.
package phivers_inject_arbiter_pkg;

    // Packet-level FSM states, in the order a packet walks through them.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        SIZE    = 2'd2,
        PAYLOAD = 2'd3
    } inj_state_t;

    // Position of the size flit within a packet (flit0 is the header).
    localparam int INJ_SIZE_FLIT_IDX = 1;

    // Plain-vector encodings of the FSM states. HEADER/SIZE follow the flit
    // position inside the packet, so SIZE sits INJ_SIZE_FLIT_IDX after HEADER.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_SIZE    = 2'(1 + INJ_SIZE_FLIT_IDX);
    localparam logic [1:0] ST_PAYLOAD = 2'd3;

endpackage

// File: rtl/phivers_flit_fifo.sv
// Registered circular flit buffer with full/empty flags.
// Head entry is presented combinationally on rdata_o; writes land one edge
// after push_i, so a flit pushed into an empty buffer is visible right after
// that edge. Push while full and pop while empty are ignored.
module phivers_flit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr];

    // Storage array: written at the tail, never reset (guarded by empty_o).
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/phivers_inject_arbiter.sv
// N-channel whole-packet round-robin injector for the many-core boundary port.
// Both sides are credit based: a flit moves in any cycle where valid and
// credit are both high (src_rx_i & src_credit_o upstream, tx_o & credit_i
// downstream); credit never depends combinationally on valid.
// Optional build macro PHIVERS_INJ_STATS_EN adds per-channel completed-packet
// counters on pkt_cnt_o.
module phivers_inject_arbiter
    import phivers_inject_arbiter_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int FLIT_SIZE = 32,
    parameter int BUF_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_CH-1:0]           src_rx_i,
    output logic [N_CH-1:0]           src_credit_o,
    input  logic [N_CH*FLIT_SIZE-1:0] src_data_i,
    output logic                      tx_o,
    input  logic                      credit_i,
    output logic [FLIT_SIZE-1:0]      data_o,
    output logic [$clog2(N_CH):0]     grant_o,
    output logic                      busy_o,
    output logic [1:0]                dbg_state_o
`ifdef PHIVERS_INJ_STATS_EN
    ,
    output logic [N_CH*32-1:0]        pkt_cnt_o
`endif
);

    localparam int            GW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [GW-1:0] LAST = GW'(N_CH - 1);

    logic [1:0]           state;
    logic [GW-1:0]        grant;
    logic [GW-1:0]        rr_ptr;
    logic [FLIT_SIZE-1:0] cnt;
    logic [GW-1:0]        pick;
    logic                 pick_vld;
    int                   rr_idx;
    logic [FLIT_SIZE-1:0] src_flit;
    logic                 acc;
    logic                 done;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [FLIT_SIZE-1:0] fifo_head;
    logic [FLIT_SIZE-1:0] last_q;

    assign src_flit = src_data_i[int'(grant)*FLIT_SIZE +: FLIT_SIZE];
    assign acc      = (state != ST_IDLE) && src_rx_i[grant] && !fifo_full;
    assign done     = acc && (((state == ST_SIZE) && (src_flit == '0)) ||
                              ((state == ST_PAYLOAD) && (cnt == FLIT_SIZE'(1))));
    assign fifo_pop = !fifo_empty && credit_i;

    // Round-robin search: first requesting channel at or above rr_ptr, with wrap.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        rr_idx   = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            rr_idx = (int'(rr_ptr) + i) % N_CH;
            if (src_rx_i[rr_idx]) begin
                pick     = rr_idx[GW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Only the granted channel gets credit, and only while there is FIFO room.
    always_comb begin
        src_credit_o = '0;
        if ((state != ST_IDLE) && !fifo_full) begin
            src_credit_o[grant] = 1'b1;
        end
    end

    // Packet FSM, payload down-counter and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant <= pick;
                        state <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (acc) state <= ST_SIZE;
                end
                ST_SIZE: begin
                    if (acc) begin
                        cnt   <= src_flit;
                        state <= (src_flit == '0) ? ST_IDLE : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (acc) begin
                        cnt <= cnt - FLIT_SIZE'(1);
                        if (cnt == FLIT_SIZE'(1)) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (done) begin
                rr_ptr <= (grant == LAST) ? '0 : grant + 1'b1;
            end
        end
    end

    phivers_flit_fifo #(
        .WIDTH (FLIT_SIZE),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (acc),
        .wdata_i (src_flit),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Remember the last flit handed downstream so data_o holds it while empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= '0;
        end else if (fifo_pop) begin
            last_q <= fifo_head;
        end
    end

    assign tx_o        = !fifo_empty;
    assign data_o      = fifo_empty ? last_q : fifo_head;
    assign busy_o      = (state != ST_IDLE);
    assign dbg_state_o = state;

    generate
        if (N_CH > 1) begin : g_grant_multi
            assign grant_o = {busy_o, grant};
        end else begin : g_grant_single
            assign grant_o = busy_o;
        end
    endgenerate

`ifdef PHIVERS_INJ_STATS_EN
    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_stats
            logic [31:0] pkt_cnt_q;
            // Completed-packet count for channel c, wrapping at 2^32.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    pkt_cnt_q <= '0;
                end else if (done && (grant == GW'(c))) begin
                    pkt_cnt_q <= pkt_cnt_q + 32'd1;
                end
            end
            assign pkt_cnt_o[c*32 +: 32] = pkt_cnt_q;
        end
    endgenerate
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
